scoreboard_top_core: RTL and testbench

Single-score scoreboard for two pushbuttons, clocked at 1 kHz.
- Each button is synchronised, debounced and classified as a short or long press.
- Press events drive a 0..99 score counter.
- The score is shown on two 7-segment digits (tens, ones).
- Top of the scoreboard datapath; drives the display pins directly.

---
 rtl/scoreboard_pkg.sv | 46 ++++
 rtl/button_event_unit.sv | 92 +++++++++
 rtl/scoreboard_top_core.sv | 75 +++++++
 tb/tb_scoreboard_top_core.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared constants, press-FSM state type and 7-segment decoder for the scoreboard.
package scoreboard_pkg;

    localparam int unsigned SCORE_W             = 7;
    localparam int unsigned DEBOUNCE_MS_DEFAULT = 10;
    localparam int unsigned LONG_MS_DEFAULT     = 1000;

    // Active-high segments, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StLongDone
    } press_state_e;

    // Digits above 9 cannot occur for a score <= 99; they show blank.
    function automatic logic [6:0] seg_decode(input logic [SCORE_W-1:0] digit);
        logic [6:0] seg;
        case (digit)
            7'd0:    seg = SEG_0;
            7'd1:    seg = SEG_1;
            7'd2:    seg = SEG_2;
            7'd3:    seg = SEG_3;
            7'd4:    seg = SEG_4;
            7'd5:    seg = SEG_5;
            7'd6:    seg = SEG_6;
            7'd7:    seg = SEG_7;
            7'd8:    seg = SEG_8;
            7'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/button_event_unit.sv
// Per-button synchroniser, debouncer and short/long press classifier.
module button_event_unit
    import scoreboard_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
    parameter int unsigned LONG_MS     = LONG_MS_DEFAULT
) (
    input  logic clk_1khz_i,
    input  logic rst_ni,
    input  logic button_i,
    output logic short_o,
    output logic long_o
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_MS + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_MS);

    logic [1:0]        sync_q;
    logic              deb_q, deb_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    press_state_e      state_q, state_d;

    // Debounce: accept the synchronised level only after it has differed for DEBOUNCE_MS cycles.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync_q[1] != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Press FSM: classify each debounced press as short or long, one pulse per press.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        short_o = 1'b0;
        long_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (deb_q) begin
                    state_d = StHeld;
                    hold_d  = '0;
                end
            end
            StHeld: begin
                if (!deb_q) begin
                    short_o = 1'b1;
                    state_d = StIdle;
                end else if (hold_q == HOLD_LAST) begin
                    long_o  = 1'b1;
                    hold_d  = HOLD_MAX;
                    state_d = StLongDone;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            StLongDone: begin
                // Release after a long press is silent.
                if (!deb_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any press in progress.
    always_ff @(posedge clk_1khz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
            hold_q    <= '0;
            state_q   <= StIdle;
        end else begin
            sync_q    <= {sync_q[0], button_i};
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
        end
    end

endmodule

// File: rtl/scoreboard_top_core.sv
// Two-button scoreboard: press events drive a 0..MAX_SCORE counter shown on two 7-seg digits.
module scoreboard_top_core
    import scoreboard_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
    parameter int unsigned LONG_MS     = LONG_MS_DEFAULT,
    parameter int unsigned MAX_SCORE   = 99
) (
    input  logic       clk_1khz_i,
    input  logic       rst_ni,
    input  logic       pushbutton_p1_i,
    input  logic       pushbutton_p2_i,
    output logic [6:0] seg_tens_o,
    output logic [6:0] seg_ones_o
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] TEN       = SCORE_W'(10);

    logic               p1_short, p1_long, p2_short, p2_long;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] tens, ones;

    button_event_unit #(
        .DEBOUNCE_MS(DEBOUNCE_MS),
        .LONG_MS    (LONG_MS)
    ) u_p1 (
        .clk_1khz_i(clk_1khz_i),
        .rst_ni    (rst_ni),
        .button_i  (pushbutton_p1_i),
        .short_o   (p1_short),
        .long_o    (p1_long)
    );

    button_event_unit #(
        .DEBOUNCE_MS(DEBOUNCE_MS),
        .LONG_MS    (LONG_MS)
    ) u_p2 (
        .clk_1khz_i(clk_1khz_i),
        .rst_ni    (rst_ni),
        .button_i  (pushbutton_p2_i),
        .short_o   (p2_short),
        .long_o    (p2_long)
    );

    // Next score: long clears with priority; opposing shorts cancel each other.
    always_comb begin
        score_d = score_q;
        if (p1_long || p2_long) begin
            score_d = '0;
        end else if (p1_short && !p2_short) begin
            score_d = (score_q >= SCORE_MAX) ? '0 : score_q + SCORE_W'(1);
        end else if (p2_short && !p1_short) begin
            score_d = (score_q == '0) ? '0 : score_q - SCORE_W'(1);
        end
    end

    // Score register.
    always_ff @(posedge clk_1khz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    // Decimal split and segment decode straight from the register.
    always_comb begin
        tens       = score_q / TEN;
        ones       = score_q % TEN;
        seg_tens_o = seg_decode(tens);
        seg_ones_o = seg_decode(ones);
    end

endmodule

// File: tb/tb_scoreboard_top_core.sv
// Directed self-checking bench for scoreboard_top_core; one clock period stands for 1 ms.
`timescale 1ns/1ps
module tb_scoreboard_top_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p1;
    logic       p2;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;

    int n_vec = 0;
    int n_err = 0;

    // Expected digit patterns 0..9.
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    scoreboard_top_core dut (
        .clk_1khz_i     (clk),
        .rst_ni         (rst_n),
        .pushbutton_p1_i(p1),
        .pushbutton_p2_i(p2),
        .seg_tens_o     (seg_tens),
        .seg_ones_o     (seg_ones)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic p1_press(input int high, input int low);
        p1 = 1'b1;
        tick(high);
        p1 = 1'b0;
        tick(low);
    endtask

    task automatic p2_press(input int high, input int low);
        p2 = 1'b1;
        tick(high);
        p2 = 1'b0;
        tick(low);
    endtask

    // Bouncy press: 1/2/1 ms glitches, 25 ms stable, 2/1/1 ms release glitches, 500 ms total.
    task automatic p1_bounce_press();
        p1 = 1'b1; tick(1);  p1 = 1'b0; tick(1);
        p1 = 1'b1; tick(2);  p1 = 1'b0; tick(1);
        p1 = 1'b1; tick(1);  p1 = 1'b0; tick(1);
        p1 = 1'b1; tick(25);
        p1 = 1'b0; tick(2);  p1 = 1'b1; tick(1);
        p1 = 1'b0; tick(1);  p1 = 1'b1; tick(1);
        p1 = 1'b0; tick(463);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        p1    = 1'b0;
        p2    = 1'b0;
        tick(2);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL reset_hold: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
        rst_n = 1'b1;
        tick(3);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL reset_release: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
    endtask

    task automatic test_long_from_zero();
        p1 = 1'b1;
        tick(1600);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL long_hold_zero: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
        p1 = 1'b0;
        tick(40);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL long_release_no_short: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
    endtask

    task automatic test_long_clear();
        for (int i = 0; i < 3; i++) p1_press(20, 20);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h4F) begin
            n_err++;
            $display("FAIL three_shorts: got %h %h, required 3f 4f", seg_tens, seg_ones);
        end
        p1 = 1'b1;
        tick(1012);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h4F) begin
            n_err++;
            $display("FAIL long_before_clear: got %h %h, required 3f 4f", seg_tens, seg_ones);
        end
        tick(1);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL long_clear_1013: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
        tick(587);
        p1 = 1'b0;
        tick(40);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL long_clear_release: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
    endtask

    task automatic test_bouncy();
        for (int i = 1; i <= 10; i++) begin
            p1_bounce_press();
            n_vec++;
            if (seg_tens !== seg_tab[i / 10] || seg_ones !== seg_tab[i % 10]) begin
                n_err++;
                $display("FAIL bounce_press_%0d: got %h %h, required %h %h", i, seg_tens,
                         seg_ones, seg_tab[i / 10], seg_tab[i % 10]);
            end
        end
    endtask

    task automatic test_glitch();
        p1 = 1'b1;
        tick(5);
        p1 = 1'b0;
        tick(50);
        n_vec++;
        if (seg_tens !== 7'h06 || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL glitch_5ms: got %h %h, required 06 3f", seg_tens, seg_ones);
        end
    endtask

    task automatic test_p2();
        p2_press(20, 20);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h6F) begin
            n_err++;
            $display("FAIL p2_dec_10_to_9: got %h %h, required 3f 6f", seg_tens, seg_ones);
        end
        for (int i = 0; i < 9; i++) p2_press(20, 20);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL p2_dec_to_0: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
        p2_press(20, 20);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL p2_saturate_0: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 99; i++) p1_press(15, 20);
        n_vec++;
        if (seg_tens !== 7'h6F || seg_ones !== 7'h6F) begin
            n_err++;
            $display("FAIL count_to_99: got %h %h, required 6f 6f", seg_tens, seg_ones);
        end
        p1_press(15, 20);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL wrap_99_to_0: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) p1_press(15, 20);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h6D) begin
            n_err++;
            $display("FAIL five_shorts: got %h %h, required 3f 6d", seg_tens, seg_ones);
        end
        p1 = 1'b1;
        p2 = 1'b1;
        tick(20);
        p1 = 1'b0;
        p2 = 1'b0;
        tick(30);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h6D) begin
            n_err++;
            $display("FAIL simultaneous_shorts: got %h %h, required 3f 6d", seg_tens, seg_ones);
        end
    endtask

    task automatic test_p2_long();
        p2 = 1'b1;
        tick(1100);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL p2_long_clear: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
        p2 = 1'b0;
        tick(40);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL p2_long_release: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) p1_press(15, 20);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h4F) begin
            n_err++;
            $display("FAIL pre_reset_score: got %h %h, required 3f 4f", seg_tens, seg_ones);
        end
        p1 = 1'b1;
        tick(500);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL async_reset_mid: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
        p1 = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(50);
        n_vec++;
        if (seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
            n_err++;
            $display("FAIL reset_abort_press: got %h %h, required 3f 3f", seg_tens, seg_ones);
        end
    endtask

    initial begin
        test_reset();
        test_long_from_zero();
        test_long_clear();
        test_bouncy();
        test_glitch();
        test_p2();
        test_wrap();
        test_back_to_back();
        test_p2_long();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
